rampipe_param: RTL

- Parametrised successor of the pipelined single-port RAM block.
- Holds a behavioural (synthesisable) DEPTH x DW single-port array with a macro-style active-low interface and per-lane active-low write masks.
- Output passes through a configurable registered pipeline with valid tracking, pipeline-wide stall, and per-lane even-parity checking.
- Sits between datapath control and any consumer that needs fixed, known read latency.

---
 rtl/rampipe_param.sv | 96 +++++++++
 1 files changed

// File: rtl/rampipe_param.sv
// Behavioural single-port RAM with an active-low macro interface, per-lane write masks and stored
// even parity, followed by a stallable output pipeline that checks parity per lane.
module rampipe_param #(
    parameter int AW    = 7,
    parameter int DW    = 16,
    parameter int LANES = 2,
    parameter int PIPE  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [AW-1:0]    A,
    input  logic [DW-1:0]    D,
    input  logic             OEN,
    input  logic             WEN,
    input  logic [LANES-1:0] BWEN,
    input  logic             INJ,
    input  logic             HOLD,
    output logic [DW-1:0]    Q,
    output logic             QV,
    output logic [LANES-1:0] PERR
);
    localparam int DEPTH = 2 ** AW;
    localparam int LW    = DW / LANES;
    localparam int NST   = PIPE + 1;

    if ((DW % LANES) != 0 || PIPE < 0 || PIPE > 4) begin : g_param_check
        $error("rampipe_param: DW must divide evenly into LANES and PIPE must be 0..4");
    end

    logic [DW-1:0]    mem     [DEPTH];
    logic [LANES-1:0] par_mem [DEPTH];

    logic             wr_en;
    logic             rd_en;

    // A write takes the port, so OEN is ignored whenever WEN is asserted.
    assign wr_en = !RST && !HOLD && !WEN;
    assign rd_en = !HOLD && WEN && !OEN;

    // Array write: only unmasked lanes update data and parity.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (!BWEN[i]) begin
                    mem[A][i*LW +: LW] <= D[i*LW +: LW];
                    par_mem[A][i]      <= (^D[i*LW +: LW]) ^ INJ;
                end
            end
        end
    end

    // Stage p0 is the array read register; stages p1..pPIPE are the output pipe.
    logic [DW-1:0]    data_p [NST];
    logic [LANES-1:0] par_p  [NST];
    logic [NST-1:0]   vld_p;

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p <= '0;
            for (int s = 0; s < NST; s++) begin
                data_p[s] <= '0;
                par_p[s]  <= '0;
            end
        end else if (!HOLD) begin
            vld_p[0] <= rd_en;
            if (rd_en) begin
                data_p[0] <= mem[A];
                par_p[0]  <= par_mem[A];
            end
            // Bubbles advance the valid bit only, so Q keeps its last read value.
            for (int s = 1; s < NST; s++) begin
                vld_p[s] <= vld_p[s-1];
                if (vld_p[s-1]) begin
                    data_p[s] <= data_p[s-1];
                    par_p[s]  <= par_p[s-1];
                end
            end
        end
    end

    function automatic logic [LANES-1:0] lane_check(input logic [DW-1:0] data,
                                                    input logic [LANES-1:0] par,
                                                    input logic vld);
        logic [LANES-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[i] = vld & ((^data[i*LW +: LW]) ^ par[i]);
        end
        return r;
    endfunction

    assign Q    = data_p[NST-1];
    assign QV   = vld_p[NST-1];
    assign PERR = lane_check(data_p[NST-1], par_p[NST-1], vld_p[NST-1]);

endmodule
